// File: rtl/btn_debounce_edge_if.sv
// rtl/btn_debounce_edge_if.sv - signal bundle between a raw push-button and its conditioner
interface btn_debounce_edge_if;
   logic btn_in;
   logic btn_level;
   logic btn_pulse;
   logic btn_release;

   modport master (output btn_in, input btn_level, btn_pulse, btn_release);
   modport slave (input btn_in, output btn_level, btn_pulse, btn_release);
endinterface

// File: rtl/btn_debounce_edge.sv
// rtl/btn_debounce_edge.sv - synchronise, debounce and edge-detect one push-button
// Optional auto-repeat while held: define BTN_AUTO_REPEAT_EN.
module btn_debounce_edge #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_WIDTH       = 20,
   parameter int unsigned REPEAT_CYCLES   = 25000000
) (
   input logic                clk,
   input logic                reset,
   btn_debounce_edge_if.slave btn
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_WIDTH)) begin : g_bad_db
      $error("DEBOUNCE_CYCLES out of range for CNT_WIDTH");
   end

`ifdef BTN_AUTO_REPEAT_EN
   localparam logic [CNT_WIDTH-1:0] RP_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

   if (REPEAT_CYCLES < 1 || 64'(REPEAT_CYCLES) > (64'd1 << CNT_WIDTH)) begin : g_bad_rp
      $error("REPEAT_CYCLES out of range for CNT_WIDTH");
   end
`else
   if (REPEAT_CYCLES == 0) begin : g_bad_rp
      $error("REPEAT_CYCLES must be nonzero");
   end
`endif

   state_t               state, state_nx;
   logic                 sync0, sync1;
   logic [CNT_WIDTH-1:0] cnt, cnt_nx;
   logic                 level_nx, pulse_nx, release_nx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync0           <= 1'b0;
         sync1           <= 1'b0;
         state           <= IDLE;
         cnt             <= '0;
         btn.btn_level   <= 1'b0;
         btn.btn_pulse   <= 1'b0;
         btn.btn_release <= 1'b0;
      end else begin
         sync0           <= btn.btn_in;
         sync1           <= sync0;
         state           <= state_nx;
         cnt             <= cnt_nx;
         btn.btn_level   <= level_nx;
         btn.btn_pulse   <= pulse_nx;
         btn.btn_release <= release_nx;
      end
   end

   // Outputs are the registered image of the next-state decision, so they
   // change on the same edge as the state they describe.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      level_nx   = 1'b0;
      pulse_nx   = 1'b0;
      release_nx = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (sync1) state_nx = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!sync1) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == DB_LAST) begin
               state_nx = HELD;
               cnt_nx   = '0;
               level_nx = 1'b1;
               pulse_nx = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         HELD: begin
            level_nx = 1'b1;
            if (!sync1) begin
               state_nx = RELEASE_WAIT;
               cnt_nx   = '0;
            end else begin
`ifdef BTN_AUTO_REPEAT_EN
               if (cnt == RP_LAST) begin
                  cnt_nx   = '0;
                  pulse_nx = 1'b1;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
`else
               cnt_nx = '0;
`endif
            end
         end
         RELEASE_WAIT: begin
            level_nx = 1'b1;
            if (sync1) begin
               state_nx = HELD;
               cnt_nx   = '0;
            end else if (cnt == DB_LAST) begin
               state_nx   = IDLE;
               cnt_nx     = '0;
               level_nx   = 1'b0;
               release_nx = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_btn_debounce_edge.sv
// tb/tb_btn_debounce_edge.sv - self-checking bench for btn_debounce_edge
module tb_btn_debounce_edge;
   localparam int DB  = 8;
   localparam int RP  = 16;
   localparam int LAT = DB + 2;
`ifdef BTN_AUTO_REPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   typedef struct {
      logic btn;
      int   cycles;
      logic level;
      int   pulses;
      int   rels;
   } seg_t;

   typedef struct {
      logic pulse;
      logic rel;
      logic level;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   btn_debounce_edge_if bif ();

   btn_debounce_edge #(
      .DEBOUNCE_CYCLES(DB),
      .CNT_WIDTH      (20),
      .REPEAT_CYCLES  (RP)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .btn  (bif.slave)
   );

   always #5 clk = ~clk;

   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   overlap = 0;
   seg_t seg_q[$];
   exp_t exp_q[$];
   seg_t tbl[7];

   always @(negedge clk) if (bif.btn_pulse === 1'b1 && bif.btn_release === 1'b1) overlap++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_seg(input int idx);
      int   p = 0;
      int   r = 0;
      seg_t e;
      bif.btn_in = tbl[idx].btn;
      seg_q.push_back(tbl[idx]);
      for (int k = 0; k < tbl[idx].cycles; k++) begin
         step();
         p += int'(bif.btn_pulse);
         r += int'(bif.btn_release);
      end
      e = seg_q.pop_front();
      check($sformatf("seg%0d_pulses", idx), p, e.pulses);
      check($sformatf("seg%0d_releases", idx), r, e.rels);
      check($sformatf("seg%0d_level", idx), {31'd0, bif.btn_level}, {31'd0, e.level});
   endtask

   task automatic push_press(input int cycles);
      exp_t e;
      for (int k = 0; k < cycles; k++) begin
         e.pulse = (k == LAT) || (AUTO && k > LAT && ((k - LAT) % RP) == 0);
         e.rel   = 1'b0;
         e.level = (k >= LAT);
         exp_q.push_back(e);
      end
   endtask

   task automatic push_release(input int cycles);
      exp_t e;
      for (int k = 0; k < cycles; k++) begin
         e.pulse = 1'b0;
         e.rel   = (k == LAT);
         e.level = (k < LAT);
         exp_q.push_back(e);
      end
   endtask

   task automatic drain(input string name);
      exp_t e;
      int   k = 0;
      while (exp_q.size() > 0) begin
         step();
         e = exp_q.pop_front();
         check($sformatf("%s_pulse@%0d", name, k), {31'd0, bif.btn_pulse}, {31'd0, e.pulse});
         check($sformatf("%s_release@%0d", name, k), {31'd0, bif.btn_release}, {31'd0, e.rel});
         check($sformatf("%s_level@%0d", name, k), {31'd0, bif.btn_level}, {31'd0, e.level});
         k++;
      end
   endtask

   initial begin
      // bounce reject, clean press, then release with bounce
      tbl[0] = '{1'b1, 5, 1'b0, 0, 0};
      tbl[1] = '{1'b0, 3, 1'b0, 0, 0};
      tbl[2] = '{1'b1, 5, 1'b0, 0, 0};
      tbl[3] = '{1'b0, 20, 1'b0, 0, 0};
      tbl[4] = '{1'b1, 40, 1'b1, (AUTO ? 2 : 1), 0};
      tbl[5] = '{1'b0, 4, 1'b1, 0, 0};
      tbl[6] = '{1'b1, 2, 1'b1, 0, 0};

      reset      = 1'b1;
      bif.btn_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_level", {31'd0, bif.btn_level}, 32'd0);
      check("reset_pulse", {31'd0, bif.btn_pulse}, 32'd0);
      check("reset_release", {31'd0, bif.btn_release}, 32'd0);
      #2 reset = 1'b0;

      for (int i = 0; i < 7; i++) run_seg(i);
      tbl[0] = '{1'b0, 20, 1'b0, 0, 1};
      run_seg(0);

      bif.btn_in = 1'b1;
      push_press(60);
      drain("press");
      bif.btn_in = 1'b0;
      push_release(20);
      drain("release");

      // asynchronous reset while HELD, button kept down throughout
      bif.btn_in = 1'b1;
      push_press(12);
      drain("pre_reset");
      #2 reset = 1'b1;
      #1;
      check("async_level", {31'd0, bif.btn_level}, 32'd0);
      check("async_pulse", {31'd0, bif.btn_pulse}, 32'd0);
      check("async_release", {31'd0, bif.btn_release}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("in_reset_level", {31'd0, bif.btn_level}, 32'd0);
      #2 reset = 1'b0;
      push_press(14);
      drain("post_reset");
      bif.btn_in = 1'b0;
      push_release(20);
      drain("final_release");

      check("pulse_release_overlap", overlap, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
